// File: rtl/axi_pkg.sv
// Shared types and constants for the AXI4-Lite to BRAM port controller.
package axi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WRESP,
    RWAIT,
    RDATA
  } state_t;

  typedef enum logic {
    READ,
    WRITE
  } grant_t;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

endpackage

// File: rtl/axi_bram_ctrl.sv
// AXI4-Lite slave driving one port of a dual-port RAM; one transaction in
// flight, read/write arbitration alternates on ties.
module axi_bram_ctrl
  import axi_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int LATENCY    = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic [2:0]            s_axi_awprot,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [31:0]           s_axi_wdata,
  input  logic [3:0]            s_axi_wstrb,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic [2:0]            s_axi_arprot,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [31:0]           s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready,
  output logic                  bram_en,
  output logic [3:0]            bram_we,
  output logic [ADDR_WIDTH-3:0] bram_addr,
  output logic [31:0]           bram_wrdata,
  input  logic [31:0]           bram_rddata
);

  localparam int CNT_W = $clog2(LATENCY + 1);

  state_t            state_reg, state_next;
  grant_t            last_grant_reg, last_grant_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [31:0]       rdata_reg, rdata_next;

  logic wr_elig, rd_elig, grant_wr, grant_rd;

  // Protection bits and byte-lane address bits carry no meaning for a word RAM.
  logic unused_inputs;
  assign unused_inputs = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr[1:0], s_axi_araddr[1:0]};

  assign wr_elig  = s_axi_awvalid && s_axi_wvalid;
  assign rd_elig  = s_axi_arvalid;
  assign grant_wr = (state_reg == IDLE) && wr_elig && (!rd_elig || last_grant_reg == READ);
  assign grant_rd = (state_reg == IDLE) && rd_elig && (!wr_elig || last_grant_reg == WRITE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      last_grant_reg <= READ;
      cnt_reg        <= '0;
      rdata_reg      <= '0;
    end else begin
      state_reg      <= state_next;
      last_grant_reg <= last_grant_next;
      cnt_reg        <= cnt_next;
      rdata_reg      <= rdata_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    last_grant_next = last_grant_reg;
    cnt_next        = cnt_reg;
    rdata_next      = rdata_reg;
    s_axi_awready   = 1'b0;
    s_axi_wready    = 1'b0;
    s_axi_arready   = 1'b0;
    bram_en         = 1'b0;
    bram_we         = 4'b0000;
    bram_addr       = s_axi_awaddr[ADDR_WIDTH-1:2];
    bram_wrdata     = s_axi_wdata;

    case (state_reg)
      IDLE: begin
        if (grant_wr) begin
          s_axi_awready   = 1'b1;
          s_axi_wready    = 1'b1;
          bram_en         = 1'b1;
          bram_we         = s_axi_wstrb;
          last_grant_next = WRITE;
          state_next      = WRESP;
        end else if (grant_rd) begin
          s_axi_arready   = 1'b1;
          bram_en         = 1'b1;
          bram_addr       = s_axi_araddr[ADDR_WIDTH-1:2];
          cnt_next        = CNT_W'(LATENCY - 1);
          last_grant_next = READ;
          state_next      = RWAIT;
        end
      end
      WRESP: begin
        if (s_axi_bready) state_next = IDLE;
      end
      RWAIT: begin
        // RAM output is valid in the cycle the counter has run down to zero.
        if (cnt_reg == '0) begin
          rdata_next = bram_rddata;
          state_next = RDATA;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      RDATA: begin
        if (s_axi_rready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign s_axi_bvalid = (state_reg == WRESP);
  assign s_axi_rvalid = (state_reg == RDATA);
  assign s_axi_bresp  = AXI_RESP_OKAY;
  assign s_axi_rresp  = AXI_RESP_OKAY;
  assign s_axi_rdata  = rdata_reg;

endmodule

// File: doc/axi_bram_ctrl.md
# axi_bram_ctrl

AXI4-Lite slave that sequences one port of the on-chip dual-port RAM, replacing the vendor BRAM controller IP on the CPU's imem and dmem buses. It accepts single-beat reads and writes, arbitrates between read and write channels for the single RAM port, and drives the RAM's enable, byte-write-enable, word-address and write-data inputs. Two instances sit between the CPU and the two RAM ports in the FPGA top level.

## Interface
- ADDR_WIDTH, 16, byte-address width; RAM word address is ADDR_WIDTH-2 bits.
- LATENCY, 1, RAM read latency in cycles (≥1); must match the RAM instance.

Ports:
- clk  in  1  single clock for AXI and RAM port.
- reset  in  1  synchronous, active-high.
- s_axi_awaddr  in  ADDR_WIDTH  write byte address.
- s_axi_awprot  in  3  ignored.
- s_axi_awvalid / s_axi_awready  in / out  1  AW handshake.
- s_axi_wdata  in  32  write data.
- s_axi_wstrb  in  4  byte strobes.
- s_axi_wvalid / s_axi_wready  in / out  1  W handshake.
- s_axi_bresp  out  2  always 2'b00 (OKAY).
- s_axi_bvalid / s_axi_bready  out / in  1  B handshake.
- s_axi_araddr  in  ADDR_WIDTH  read byte address.
- s_axi_arprot  in  3  ignored.
- s_axi_arvalid / s_axi_arready  in / out  1  AR handshake.
- s_axi_rdata  out  32  read data (registered).
- s_axi_rresp  out  2  always 2'b00.
- s_axi_rvalid / s_axi_rready  out / in  1  R handshake.
- bram_en  out  1  RAM port enable.
- bram_we  out  4  RAM byte write enables.
- bram_addr  out  ADDR_WIDTH-2  RAM word address.
- bram_wrdata  out  32  RAM write data.
- bram_rddata  in  32  RAM read data.

## Operation
- One transaction in flight; no outstanding-request queueing.
- FSM states: IDLE, WRESP, RWAIT, RDATA.
- IDLE: write is eligible when awvalid && wvalid (AW and W are accepted together, never separately); read is eligible when arvalid.
- Arbitration: if only one is eligible, grant it. If both are eligible, grant the one opposite to last_grant. last_grant resets to READ, so a write wins the first tie.
- Write grant (IDLE): awready=wready=1, bram_en=1, bram_we=wstrb, bram_addr=awaddr[ADDR_WIDTH-1:2], bram_wrdata=wdata, all combinational in that cycle. Next state is WRESP.
- WRESP: bvalid=1 until bready, then go to IDLE.
- Read grant (IDLE): arready=1, bram_en=1, bram_we=0, bram_addr=araddr[ADDR_WIDTH-1:2]. Load the latency counter with LATENCY-1. Next state is RWAIT.
- RWAIT: decrement the counter. When it reaches 0, register bram_rddata into rdata and go to RDATA.
- RDATA: rvalid=1 and rdata stays stable until rready, then go to IDLE.
- wstrb=0 still performs the handshake and response; the RAM is left unmodified.
- Address bits [1:0] are ignored. Bits above ADDR_WIDTH are truncated by the instantiator, so addresses wrap modulo 2^ADDR_WIDTH.
- Outside a grant cycle: bram_en=0, bram_we=0. bram_addr and bram_wrdata are don't-care, but are driven from awaddr/wdata to avoid latches.

## Timing
- Reset values: all ready/valid outputs 0, bresp=rresp=0, rdata=0, bram_en=0, bram_we=0, state=IDLE, last_grant=READ.
- Write: handshake in cycle 0, bvalid from cycle 1. Minimum 2 cycles per write.
- Read: handshake in cycle 0, rvalid from cycle LATENCY+1. Minimum LATENCY+2 cycles per read.
- Ready signals depend combinationally on valid and state only, never on bready or rready.
- bvalid and rvalid never deassert without their handshake, except on reset.
- Reset asserted in any state: state returns to IDLE the next cycle, and bvalid/rvalid drop. An in-flight response is discarded; the master shares the same reset.
- A request arriving in the same cycle that bready/rready completes the previous response waits until IDLE (one cycle later).

## Structure
- A shared package (axi_pkg) holds the state enum, the grant type (READ/WRITE), and the AXI_RESP_OKAY/SLVERR/DECERR constants.
- Single module with no sub-modules. The latency counter is $clog2(LATENCY+1) bits, inline.

## Test plan
- Write 0xDEADBEEF to 0x0010 with wstrb=4'hF, then read 0x0010: bram_we=4'hF with addr=4 in the write grant cycle; rdata=0xDEADBEEF; rvalid in cycle LATENCY+1 after the AR handshake.
- Byte write 0x000000AA to 0x0010 with wstrb=4'b0001 after the above: readback is 0xDEADBEAA.
- awvalid, wvalid and arvalid held simultaneously for 4 transactions: grants alternate W,R,W,R starting with W after reset.
- awvalid without wvalid for 5 cycles: awready stays 0 and the RAM is untouched. When wvalid rises, both readies pulse in the same cycle.
- bready held low 10 cycles: bvalid stays 1, no new grant occurs, then the response completes and the next AR is granted one cycle later.
- Reset asserted during RWAIT with LATENCY=3: next cycle state is IDLE and rvalid=0. A subsequent read of 0xFFFC wraps to word address 0x3FFF.
